// File: rtl/tdm_demux4.sv
// tdm_demux4: reassembles a 4-slot TDM stream into a parallel frame, locking on sof
module tdm_demux4 #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           sof,
  output logic [4*W-1:0] y,
  output logic           frame_valid,
  output logic [1:0]     slot,
  output logic           locked,
  output logic           sync_err
);
  typedef enum logic {HUNT, RUN} state_t;
  state_t state;
  logic [W-1:0] sh0, sh1, sh2;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      slot        <= 2'd0;
      locked      <= 1'b0;
      y           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      // slot is always 0 while hunting, so a hunting sof beat is an ordinary slot-0 beat
      if (din_valid && (state == RUN || sof)) begin
        state  <= RUN;
        locked <= 1'b1;
        if (sof && slot != 2'd0) begin
          sync_err <= 1'b1;
          sh0      <= din;
          slot     <= 2'd1;
        end else begin
          slot <= slot + 2'd1;
          if (slot == 2'd0) sh0 <= din;
          if (slot == 2'd1) sh1 <= din;
          if (slot == 2'd2) sh2 <= din;
          if (slot == 2'd3) begin
            y           <= {din, sh2, sh1, sh0};
            frame_valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side counterpart of the team's 4-to-1 channel selector.
- Takes a time-division-multiplexed stream that carries one lane word per accepted beat, in slot order 0,1,2,3.
- Reassembles each 4-slot frame into four parallel lane registers and presents the whole frame at once with a one-cycle valid strobe.
- Locks to the stream using a start-of-frame marker and flags resynchronisation events.

Parameters:
- W, default 1: width of one lane word in bits; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- din  input  W  lane word for the current slot
- din_valid  input  1  din is valid this cycle; beat accepted when high
- sof  input  1  start of frame; qualified by din_valid; marks the beat as slot 0
- y  output  4*W  reassembled frame; lane k occupies y[k*W +: W]
- frame_valid  output  1  one-cycle pulse: y was updated on this cycle's preceding edge with a complete frame
- slot  output  2  index of the next slot expected (0..3)
- locked  output  1  high once the first sof has been accepted
- sync_err  output  1  one-cycle pulse: sof arrived mid-frame and a partial frame was discarded

Behaviour:
- Reset (rst high at a clk edge) takes priority over all inputs. Reset values:
  - state = HUNT, slot = 0, locked = 0, y = 0, frame_valid = 0, sync_err = 0
  - internal shadow lanes 0..2 = 0
- Reset mid-frame discards the partial frame; y is not updated.
- Beat: a cycle with din_valid = 1. When din_valid = 0, nothing changes except that frame_valid and sync_err return to 0. Gaps of any length between beats are legal.
- State HUNT:
  - Beats with sof = 0 are dropped silently.
  - A beat with sof = 1 stores din into shadow lane 0, sets slot = 1, sets locked = 1, and moves to state RUN.
- State RUN, beat with sof = 0:
  - slot = 0, 1 or 2: store din into shadow[slot]; slot <= slot + 1.
  - slot = 3: y <= {din, shadow2, shadow1, shadow0}; frame_valid <= 1 on the next cycle only; slot wraps to 0.
  - sof is optional at slot 0 once locked.
- State RUN, beat with sof = 1:
  - At slot = 0: normal slot-0 beat.
  - At slot = 1..3 (resync): sync_err <= 1 for one cycle; shadow contents are discarded; din is stored as the new shadow lane 0; slot <= 1. y and frame_valid are unaffected.
- Latency: frame_valid and the new y appear in the same cycle, immediately after the clk edge that accepted the slot-3 beat.
- y holds its value until the next complete frame; it is never partially updated.
- Back-to-back frames (din_valid held high) give one frame_valid pulse every 4 cycles.
- locked stays 1 until reset; there is no loss-of-lock detection.
- sof with din_valid = 0 is ignored in every state.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset then lock, W=1:
   - Stimulus: rst for 2 cycles, then continuous beats din = 1,0,1,1 with sof on the first beat.
   - Response: y = 4'b1101; frame_valid high for exactly 1 cycle, after the 4th beat edge; locked = 1 from the 1st beat; slot sequence 1,2,3,0.
2. Hunt drop, W=4:
   - Stimulus: 3 beats without sof (din = 0xA, 0xB, 0xC), then a sof frame 0x1,0x2,0x3,0x4.
   - Response: first 3 beats are ignored; locked stays 0 until the sof beat; y = 0x4321 with a single frame_valid pulse.
3. Gapped stream, W=4:
   - Stimulus: frame 0x5,0x6,0x7,0x8 with 0/2/5 idle cycles inserted between beats.
   - Response: y = 0x8765 is updated only after the last beat; y and slot are stable during gaps; frame_valid pulses exactly once.
4. Mid-frame resync, W=4:
   - Stimulus: locked, beats 0x1,0x2 (slot now 2), then a sof beat 0x9, then 0xA,0xB,0xC.
   - Response: sync_err pulses 1 cycle on the sof beat; no frame_valid for the partial frame; next y = 0xCBA9.
5. Back-to-back, W=1:
   - Stimulus: 3 consecutive frames with din_valid held high.
   - Response: frame_valid on cycles 4, 8, 12 after the first beat; y matches each frame; no sync_err.
6. Reset mid-frame:
   - Stimulus: rst asserted after 2 beats of a frame.
   - Response: y = 0, locked = 0, slot = 0; the subsequent non-sof beats are dropped until a new sof arrives.
